// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and helpers for the hazard scoreboard unit
//
// Purpose: default geometry of the hazard block, the "read register file"
// forward-select encoding, and a constant-evaluable clog2.
// Ports: none (package).
package hazard_pkg;

  localparam int FWD_SEL_RF  = 0;  // fwd_sel value meaning "take operand from register file"
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NUM_FWD = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-register array for long-latency results
//
// Purpose: one pending bit per architectural register, set on long-latency
// issue, cleared on writeback, wiped on kill; reports RAW/WAW hits for ID.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   issue_i/_rd_i      long-latency op leaves EX, destination
//   done_i/_rd_i       long-latency result written back, destination
//   kill_i             drop all outstanding entries
//   rs_i, rs_used_i    ID source addresses and their read enables
//   rd_i, regwrite_i   ID destination and its write enable
//   pending_o          registered pending bits (bit 0 always 0)
//   hit_o              combinational RAW | WAW against pending bits
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  input  logic                      done_i,
  input  logic [ADDR_W-1:0]         done_rd_i,
  input  logic                      kill_i,
  input  logic [NUM_SRC*ADDR_W-1:0] rs_i,
  input  logic [NUM_SRC-1:0]        rs_used_i,
  input  logic [ADDR_W-1:0]         rd_i,
  input  logic                      regwrite_i,
  output logic [2**ADDR_W-1:0]      pending_o,
  output logic                      hit_o
);

  logic [2**ADDR_W-1:0] pending_q, pending_d;

  // Clear first so a same-register issue overrides the done; kill overrides all.
  always_comb begin
    pending_d = pending_q;
    if (done_i)  pending_d[done_rd_i]  = 1'b0;
    if (issue_i) pending_d[issue_rd_i] = 1'b1;
    if (kill_i)  pending_d = '0;
    pending_d[0] = 1'b0;  // x0 is never pending
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Bit 0 is always 0, so x0 sources/destinations can never hit.
  always_comb begin
    hit_o = regwrite_i && pending_q[rd_i];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_i[i] && pending_q[rs_i[i*ADDR_W +: ADDR_W]]) hit_o = 1'b1;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - EX forwarding, ID load-use and long-latency scoreboard stall
//
// Purpose: drives per-operand forward selects for EX and the ID stall that
// holds PC/IF-ID and bubbles ID/EX.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles and
// loaduse_cycles counters.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_rs                       ID/EX source addresses (slice i = operand i)
//   fwd_regwrite, fwd_rd        per forwarding stage write enable / destination (0 = youngest)
//   fwd_sel                     per-operand select: 0 = regfile, k+1 = stage k
//   id_rs, id_rs_used           IF/ID sources and which are read
//   id_rd, id_regwrite          IF/ID destination and write enable
//   ex_memread, ex_rd           ID/EX load flag and destination
//   ll_issue/_rd, ll_done/_rd   long-latency issue / writeback
//   ll_kill                     flush all outstanding long-latency ops
//   stall                       load-use or scoreboard hazard
//   pending                     scoreboard bits
//   stall_cycles, loaduse_cycles  (HAZARD_PERF_CNT_EN only)
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int SEL_W   = clog2(NUM_FWD + 1)  // derived; leave at default
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_rs,
  input  logic [NUM_FWD-1:0]        fwd_regwrite,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_rd,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      ex_memread,
  input  logic [ADDR_W-1:0]         ex_rd,
  input  logic                      ll_issue,
  input  logic [ADDR_W-1:0]         ll_issue_rd,
  input  logic                      ll_done,
  input  logic [ADDR_W-1:0]         ll_done_rd,
  input  logic                      ll_kill,
  output logic                      stall,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]               stall_cycles,
  output logic [31:0]               loaduse_cycles,
`endif
  output logic [2**ADDR_W-1:0]      pending
);

  logic load_use_hit;
  logic scoreboard_hit;

  // Scan oldest to youngest so the youngest matching stage overwrites last.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_regwrite[k] &&
            (fwd_rd[k*ADDR_W +: ADDR_W] != '0) &&
            (fwd_rd[k*ADDR_W +: ADDR_W] == ex_rs[i*ADDR_W +: ADDR_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    load_use_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_memread && (ex_rd != '0) && id_rs_used[i] &&
          (id_rs[i*ADDR_W +: ADDR_W] == ex_rd)) begin
        load_use_hit = 1'b1;
      end
    end
  end

  hazard_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_i    (ll_issue),
    .issue_rd_i (ll_issue_rd),
    .done_i     (ll_done),
    .done_rd_i  (ll_done_rd),
    .kill_i     (ll_kill),
    .rs_i       (id_rs),
    .rs_used_i  (id_rs_used),
    .rd_i       (id_rd),
    .regwrite_i (id_regwrite),
    .pending_o  (pending),
    .hit_o      (scoreboard_hit)
  );

  assign stall = load_use_hit | scoreboard_hit;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] loaduse_cycles_q, loaduse_cycles_d;

  // Saturate at all-ones rather than wrap.
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    loaduse_cycles_d = loaduse_cycles_q;
    if (stall && (stall_cycles_q != '1))          stall_cycles_d   = stall_cycles_q + 32'd1;
    if (load_use_hit && (loaduse_cycles_q != '1)) loaduse_cycles_d = loaduse_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q   <= '0;
      loaduse_cycles_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      loaduse_cycles_q <= loaduse_cycles_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign loaduse_cycles = loaduse_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed scoreboard bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  localparam int NUM_SRC = 2;
  localparam int ADDR_W  = 5;
  localparam int NUM_FWD = 2;
  localparam int SEL_W   = 2;

  // kind: 0 = fwd_sel[idx], 1 = stall, 2 = pending[idx], 3 = whole pending
  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC*ADDR_W-1:0] ex_rs;
  logic [NUM_FWD-1:0]        fwd_regwrite;
  logic [NUM_FWD*ADDR_W-1:0] fwd_rd;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [NUM_SRC*ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [ADDR_W-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      ex_memread;
  logic [ADDR_W-1:0]         ex_rd;
  logic                      ll_issue;
  logic [ADDR_W-1:0]         ll_issue_rd;
  logic                      ll_done;
  logic [ADDR_W-1:0]         ll_done_rd;
  logic                      ll_kill;
  logic                      stall;
  logic [31:0]               pending;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W),
    .NUM_FWD (NUM_FWD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_rs        (ex_rs),
    .fwd_regwrite (fwd_regwrite),
    .fwd_rd       (fwd_rd),
    .fwd_sel      (fwd_sel),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .ll_issue     (ll_issue),
    .ll_issue_rd  (ll_issue_rd),
    .ll_done      (ll_done),
    .ll_done_rd   (ll_done_rd),
    .ll_kill      (ll_kill),
    .stall        (stall),
    .pending      (pending)
  );

  task automatic expect_v(input string name, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.idx = idx; e.exp = val;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled at the falling edge; drain every queued expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = 32'(fwd_sel[e.idx*SEL_W +: SEL_W]);
        1:       act = 32'(stall);
        2:       act = 32'(pending[e.idx]);
        default: act = pending;
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_miss++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ex_rs = '0; fwd_regwrite = '0; fwd_rd = '0;
    id_rs = '0; id_rs_used = '0; id_rd = '0; id_regwrite = 1'b0;
    ex_memread = 1'b0; ex_rd = '0; ll_issue = 1'b0; ll_issue_rd = '0;
    ll_done = 1'b0; ll_done_rd = '0; ll_kill = 1'b0;

    step();
    expect_v("reset_pending", 3, 0, 32'h0);
    expect_v("reset_stall",   1, 0, 32'h0);
    expect_v("reset_sel0",    0, 0, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Forwarding priority: both stages write r5 -> youngest (stage0) wins.
    ex_rs = {5'd0, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_regwrite = 2'b11;
    expect_v("fwd_youngest", 0, 0, 32'd1);
    expect_v("fwd_rs1_x0",   0, 1, 32'd0);
    step();
    fwd_regwrite = 2'b10;
    expect_v("fwd_oldest", 0, 0, 32'd2);
    step();
    ex_rs = {5'd6, 5'd5}; fwd_rd = {5'd6, 5'd5}; fwd_regwrite = 2'b11;
    expect_v("fwd_split_op0", 0, 0, 32'd1);
    expect_v("fwd_split_op1", 0, 1, 32'd2);
    step();
    ex_rs = {5'd9, 5'd9}; fwd_rd = {5'd3, 5'd4};
    expect_v("fwd_nomatch", 0, 0, 32'd0);
    step();
    // x0 is never forwarded even with a matching write.
    ex_rs = '0; fwd_rd = '0; fwd_regwrite = 2'b01;
    expect_v("fwd_x0", 0, 0, 32'd0);
    step();
    fwd_regwrite = '0;

    // Load-use on operand 1.
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; id_rs_used = 2'b11;
    expect_v("loaduse_hit", 1, 0, 32'd1);
    step();
    id_rs_used = 2'b01;
    expect_v("loaduse_unused", 1, 0, 32'd0);
    step();
    ex_rd = 5'd0; id_rs = '0; id_rs_used = 2'b11;
    expect_v("loaduse_x0", 1, 0, 32'd0);
    step();
    ex_memread = 1'b0; id_rs = '0; id_rs_used = '0;

    // Long-latency RAW on r9.
    ll_issue = 1'b1; ll_issue_rd = 5'd9;
    step();
    ll_issue = 1'b0; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    expect_v("raw_pend9",  2, 9, 32'd1);
    expect_v("raw_stall1", 1, 0, 32'd1);
    step();
    expect_v("raw_stall2", 1, 0, 32'd1);
    ll_done = 1'b1; ll_done_rd = 5'd9;
    expect_v("raw_stall_done_cycle", 1, 0, 32'd1);
    step();
    ll_done = 1'b0;
    expect_v("raw_released", 1, 0, 32'd0);
    expect_v("raw_pend9_clr", 2, 9, 32'd0);
    step();
    id_rs = '0; id_rs_used = '0;

    // Same-cycle issue and done on r3: issue wins.
    ll_issue = 1'b1; ll_issue_rd = 5'd3; ll_done = 1'b1; ll_done_rd = 5'd3;
    step();
    expect_v("issue_wins", 3, 0, 32'h0000_0008);
    // Different registers: both take effect.
    ll_issue_rd = 5'd10; ll_done_rd = 5'd3;
    step();
    expect_v("issue_done_diff", 3, 0, 32'h0000_0400);
    // Done on an idle bit and issue to x0: no change.
    ll_issue_rd = 5'd0; ll_done_rd = 5'd5;
    step();
    expect_v("noop_x0_idle", 3, 0, 32'h0000_0400);
    // Kill overrides a same-cycle issue.
    ll_done = 1'b0; ll_issue_rd = 5'd4; ll_kill = 1'b1;
    step();
    ll_issue = 1'b0; ll_kill = 1'b0;
    expect_v("kill_all", 3, 0, 32'h0);
    step();

    // WAW on r12, then asynchronous reset mid-stall.
    ll_issue = 1'b1; ll_issue_rd = 5'd12;
    step();
    ll_issue = 1'b0; id_regwrite = 1'b1; id_rd = 5'd12; id_rs_used = '0;
    expect_v("waw_pend12", 3, 0, 32'h0000_1000);
    expect_v("waw_stall",  1, 0, 32'd1);
    step();
    rst_n = 1'b0;
    expect_v("async_rst_pending", 3, 0, 32'h0);
    expect_v("async_rst_stall",   1, 0, 32'd0);
    step();
    rst_n = 1'b1; id_regwrite = 1'b0; id_rd = '0;
    step();

    begin : drain
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      if (exp_q.size() > 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL drain: got %0d queued expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
